// File: rtl/divisor_secuencial_if.sv
// Handshake and operand/result bundle between the control unit and the sequential divider.
interface divisor_secuencial_if #(
    parameter int N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/divisor_secuencial.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock by trial subtraction,
// done pulses for one cycle with registered quotient/remainder held until the next result.
module divisor_secuencial #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    divisor_secuencial_if.slave    bus
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [N-1:0]  q_reg;
    logic [N-1:0]  rem_acc;
    logic [N-1:0]  divisor_reg;
    logic [CW-1:0] count;

    logic [N:0]    shifted;
    logic [N:0]    step_res;
    logic          no_borrow;
    logic [N-1:0]  rem_next;
    logic [N-1:0]  q_next;

    // Trial subtraction as a + ~b + 1; returns {no_borrow, restored-or-reduced remainder}.
    function automatic logic [N:0] trial_step(input logic [N:0] a, input logic [N-1:0] b);
        logic [N+1:0] sum;
        sum = {1'b0, a} + {1'b0, ~{1'b0, b}} + {{(N+1){1'b0}}, 1'b1};
        return {sum[N+1], (sum[N+1] ? sum[N-1:0] : a[N-1:0])};
    endfunction

    always_comb begin
        shifted   = {rem_acc, q_reg[N-1]};
        step_res  = trial_step(shifted, divisor_reg);
        no_borrow = step_res[N];
        rem_next  = step_res[N-1:0];
        q_next    = {q_reg[N-2:0], no_borrow};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            // Zero divisor skips RUN entirely.
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.quotient    <= '1;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state       <= RUN;
                            bus.busy    <= 1'b1;
                            q_reg       <= bus.dividend;
                            rem_acc     <= '0;
                            divisor_reg <= bus.divisor;
                            count       <= CW'(N);
                        end
                    end
                end
                RUN: begin
                    q_reg   <= q_next;
                    rem_acc <= rem_next;
                    count   <= count - 1'b1;
                    if (count == CW'(1)) begin
                        state           <= DONE;
                        bus.busy        <= 1'b0;
                        bus.done        <= 1'b1;
                        bus.quotient    <= q_next;
                        bus.remainder   <= rem_next;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
